cv32e40s_csr_bank: RTL and testbench

- Parametrised bank of NUM_CSR control/status registers sharing one write port and one read port.
- Each register has per-bit writable MASK, per-register reset value, RISC-V write/set/clear ops and an optional write-lock.
- Optional complemented shadow copy per register, checked on every read and by a background scrubber FSM that walks the bank and raises a sticky alert.
- Sits between the CSR decode logic and security-critical state (PMP/config/lock CSRs) in the core.

---
 rtl/cv32e40s_csr_bank.sv | 223 ++++++++++++++++++++++
 tb/tb_cv32e40s_csr_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_csr_bank.sv
// cv32e40s_csr_bank
//   Bank of NUM_CSR control/status registers with one write port and one read
//   port. Each register has a per-bit implemented MASK, a reset value,
//   RISC-V write/set/clear ops and an optional sticky write-lock. With
//   SHADOWCOPY = 1 every register keeps a complemented shadow. The shadow is
//   compared on every read and by a background scrubber that raises a sticky
//   alert on any main/shadow mismatch.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   wr_en_i      write request
//   wr_addr_i    write register index
//   wr_op_i      00 write, 01 set, 10 clear, 11 none (rejected)
//   wr_data_i    write operand
//   wr_lock_i    lock the target after this write (LOCKABLE registers only)
//   wr_err_o     registered pulse: previous write was rejected
//   rd_addr_i    read register index
//   rd_data_o    combinational read data (0 when out of range)
//   rd_error_o   combinational main/shadow mismatch on the read register
//   locked_o     per-register lock status
//   alert_o      sticky integrity alert
//
// Main and shadow flops must be preserved as separate cells by the
// implementation flow (dont_touch constraints), so that synthesis cannot
// merge a register with its complement.
module cv32e40s_csr_bank #(
    parameter int unsigned               NUM_CSR      = 4,
    parameter int unsigned               WIDTH        = 32,
    parameter int unsigned               AW           = 2,
    parameter bit                        SHADOWCOPY   = 1'b1,
    parameter logic [NUM_CSR*WIDTH-1:0]  RESETVALUE   = '0,
    parameter logic [NUM_CSR*WIDTH-1:0]  MASK         = '1,
    parameter logic [NUM_CSR-1:0]        LOCKABLE     = '0,
    parameter int unsigned               SCRUB_PERIOD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [1:0]         wr_op_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic               wr_lock_i,
    output logic               wr_err_o,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               rd_error_o,
    output logic [NUM_CSR-1:0] locked_o,
    output logic               alert_o
);

    typedef enum logic {
        S_WAIT,
        S_CHECK
    } scrub_state_e;

    logic [WIDTH-1:0]   reg_val [NUM_CSR];
    logic [NUM_CSR-1:0] mism;
    logic [NUM_CSR-1:0] locked_q;
    logic               wr_err_q;
    logic               alert_q;

    logic               wr_addr_ok;
    logic               rd_addr_ok;
    logic               wr_accept;
    logic               wr_reject;
    logic               wr_locked;
    logic [WIDTH-1:0]   wr_cur;
    logic [WIDTH-1:0]   wr_new;
    logic [WIDTH-1:0]   rd_sel;
    logic               rd_mism;
    logic               scrub_hit;

    assign wr_addr_ok = 32'(wr_addr_i) < NUM_CSR;
    assign rd_addr_ok = 32'(rd_addr_i) < NUM_CSR;

    // Address decode by comparison so out-of-range indices never select an
    // array element; they simply leave the defaults in place.
    always_comb begin
        wr_cur    = '0;
        wr_locked = 1'b0;
        rd_sel    = '0;
        rd_mism   = 1'b0;
        for (int unsigned i = 0; i < NUM_CSR; i++) begin
            if (wr_addr_i == AW'(i)) begin
                wr_cur    = reg_val[i];
                wr_locked = locked_q[i];
            end
            if (rd_addr_i == AW'(i)) begin
                rd_sel  = reg_val[i];
                rd_mism = mism[i];
            end
        end
    end

    always_comb begin
        case (wr_op_i)
            2'b00:   wr_new = wr_data_i;
            2'b01:   wr_new = wr_cur | wr_data_i;
            2'b10:   wr_new = wr_cur & ~wr_data_i;
            default: wr_new = wr_cur;
        endcase
    end

    assign wr_accept = wr_en_i & wr_addr_ok & (wr_op_i != 2'b11) & ~wr_locked;
    assign wr_reject = wr_en_i & ~wr_accept;

    for (genvar g = 0; g < NUM_CSR; g++) begin : g_reg
        localparam logic [WIDTH-1:0] M  = MASK[g*WIDTH +: WIDTH];
        localparam logic [WIDTH-1:0] RV = RESETVALUE[g*WIDTH +: WIDTH] & M;

        logic             we;
        logic [WIDTH-1:0] main_q;

        assign we = wr_accept && (wr_addr_i == AW'(g));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                main_q <= RV;
            end else if (we) begin
                main_q <= wr_new & M;
            end
        end

        // Unimplemented bits are tied off here, so their flops have no load.
        assign reg_val[g] = main_q & M;

        if (SHADOWCOPY) begin : g_sh
            logic [WIDTH-1:0] shadow_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_q <= ~RV;
                end else if (we) begin
                    shadow_q <= ~(wr_new & M);
                end
            end

            assign mism[g] = |(reg_val[g] ^ ~(shadow_q | ~M));
        end else begin : g_nosh
            assign mism[g] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_reject;
            for (int unsigned i = 0; i < NUM_CSR; i++) begin
                if (LOCKABLE[i] && wr_accept && wr_lock_i && (wr_addr_i == AW'(i))) begin
                    locked_q[i] <= 1'b1;
                end
            end
        end
    end

    if (SHADOWCOPY && (SCRUB_PERIOD > 0)) begin : g_scrub
        localparam int unsigned CW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

        scrub_state_e  state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [AW-1:0] idx_q, idx_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                idx_q   <= idx_d;
            end
        end

        // CHECK reads the current flop values, so a write landing in the same
        // cycle is judged on the pre-write contents.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            idx_d     = idx_q;
            scrub_hit = 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == CW'(SCRUB_PERIOD - 1)) begin
                        state_d = S_CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_CHECK: begin
                    for (int unsigned i = 0; i < NUM_CSR; i++) begin
                        if (idx_q == AW'(i)) begin
                            scrub_hit = mism[i];
                        end
                    end
                    idx_d   = (idx_q == AW'(NUM_CSR - 1)) ? '0 : idx_q + AW'(1);
                    state_d = S_WAIT;
                end
                default: state_d = S_WAIT;
            endcase
        end
    end else begin : g_noscrub
        assign scrub_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alert_q <= 1'b0;
        end else if (scrub_hit || (rd_addr_ok && rd_mism)) begin
            alert_q <= 1'b1;
        end
    end

    assign rd_data_o  = rd_addr_ok ? rd_sel : '0;
    assign rd_error_o = rd_addr_ok & rd_mism;
    assign wr_err_o   = wr_err_q;
    assign locked_o   = locked_q;
    assign alert_o    = alert_q;

endmodule

// File: tb/tb_cv32e40s_csr_bank.sv
// Directed bench for cv32e40s_csr_bank.
//   dut_a: 4 registers, reset/mask/lock/scrub-without-alert scenarios.
//   dut_b: 3 registers, out-of-range access and shadow fault injection.
module tb_cv32e40s_csr_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en_a, wr_en_b;
    logic [1:0]  wr_addr;
    logic [1:0]  wr_op;
    logic [31:0] wr_data;
    logic        wr_lock;
    logic [1:0]  rd_addr;

    logic        wr_err_a, rd_err_a, alert_a;
    logic [31:0] rd_data_a;
    logic [3:0]  locked_a;
    logic        wr_err_b, rd_err_b, alert_b;
    logic [31:0] rd_data_b;
    logic [2:0]  locked_b;

    int tests = 0;
    int fails = 0;
    int cyc;

    // Scrub check every SCRUB_PERIOD+1 cycles, NUM_CSR checks per sweep,
    // plus the registered alert.
    localparam int BOUND = (4 + 1) * 3 + 2;

    always #5 clk = ~clk;

    cv32e40s_csr_bank #(
        .NUM_CSR      (4),
        .WIDTH        (32),
        .AW           (2),
        .SHADOWCOPY   (1'b1),
        .RESETVALUE   ({32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'h0000_0000}),
        .MASK         ({32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_00FF}),
        .LOCKABLE     (4'b0001),
        .SCRUB_PERIOD (4)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_a),
        .wr_addr_i  (wr_addr),
        .wr_op_i    (wr_op),
        .wr_data_i  (wr_data),
        .wr_lock_i  (wr_lock),
        .wr_err_o   (wr_err_a),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_a),
        .rd_error_o (rd_err_a),
        .locked_o   (locked_a),
        .alert_o    (alert_a)
    );

    cv32e40s_csr_bank #(
        .NUM_CSR      (3),
        .WIDTH        (32),
        .AW           (2),
        .SHADOWCOPY   (1'b1),
        .SCRUB_PERIOD (4)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_b),
        .wr_addr_i  (wr_addr),
        .wr_op_i    (wr_op),
        .wr_data_i  (wr_data),
        .wr_lock_i  (wr_lock),
        .wr_err_o   (wr_err_b),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_b),
        .rd_error_o (rd_err_b),
        .locked_o   (locked_b),
        .alert_o    (alert_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] op, input logic [31:0] d,
                      input logic lk);
        wr_addr = a;
        wr_op   = op;
        wr_data = d;
        wr_lock = lk;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr(2'd0, 2'b11, 32'h0, 1'b0);
        rd_addr = 2'd2;
        repeat (3) step();
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_rd2", rd_data_a, 32'hA5A5_0000);
        chk("rst_rderr", {31'b0, rd_err_a}, 32'd0);
        chk("rst_alert", {31'b0, alert_a}, 32'd0);
        chk("rst_locked", {28'b0, locked_a}, 32'd0);
        chk("rst_wrerr", {31'b0, wr_err_a}, 32'd0);

        // Write / set / clear on addr 1
        rd_addr = 2'd1;
        wr(2'd1, 2'b00, 32'h0000_00F0, 1'b0);
        wr_en_a = 1'b1;
        #1;
        chk("same_cycle_old", rd_data_a, 32'h0000_0000);
        step();
        chk("write_f0", rd_data_a, 32'h0000_00F0);
        wr(2'd1, 2'b01, 32'h0000_000F, 1'b0);
        step();
        chk("set_0f", rd_data_a, 32'h0000_00FF);
        wr(2'd1, 2'b10, 32'h0000_00F0, 1'b0);
        step();
        wr_en_a = 1'b0;
        chk("clear_f0", rd_data_a, 32'h0000_000F);
        chk("wset_wrerr", {31'b0, wr_err_a}, 32'd0);

        // Masked bits on addr 0
        rd_addr = 2'd0;
        wr(2'd0, 2'b00, 32'hFFFF_FFFF, 1'b0);
        wr_en_a = 1'b1;
        step();
        wr_en_a = 1'b0;
        chk("mask_rd0", rd_data_a, 32'h0000_00FF);
        chk("mask_rderr", {31'b0, rd_err_a}, 32'd0);

        // Lock addr 0 (mask 0xFF keeps only the low byte)
        wr(2'd0, 2'b00, 32'h0000_1234, 1'b1);
        wr_en_a = 1'b1;
        step();
        wr_en_a = 1'b0;
        chk("lock_rd0", rd_data_a, 32'h0000_0034);
        chk("lock_status", {28'b0, locked_a}, 32'h1);
        wr(2'd0, 2'b00, 32'h0000_FFFF, 1'b0);
        wr_en_a = 1'b1;
        step();
        wr_en_a = 1'b0;
        chk("locked_wrerr", {31'b0, wr_err_a}, 32'd1);
        chk("locked_keep", rd_data_a, 32'h0000_0034);
        step();
        chk("wrerr_pulse", {31'b0, wr_err_a}, 32'd0);

        // Lock request on non-lockable addr 3 is ignored, write proceeds
        rd_addr = 2'd3;
        wr(2'd3, 2'b00, 32'hDEAD_BEEF, 1'b1);
        wr_en_a = 1'b1;
        step();
        wr_en_a = 1'b0;
        chk("nolock_rd3", rd_data_a, 32'hDEAD_BEEF);
        chk("nolock_status", {28'b0, locked_a}, 32'h1);
        chk("nolock_wrerr", {31'b0, wr_err_a}, 32'd0);

        // Op 11 is rejected
        wr(2'd3, 2'b11, 32'h0, 1'b0);
        wr_en_a = 1'b1;
        step();
        wr_en_a = 1'b0;
        chk("op11_wrerr", {31'b0, wr_err_a}, 32'd1);
        chk("op11_keep", rd_data_a, 32'hDEAD_BEEF);

        // Several scrub sweeps over consistent registers: no alert
        rd_addr = 2'd0;
        repeat (30) step();
        chk("scrub_noalert", {31'b0, alert_a}, 32'd0);

        // Reset clears lock and contents
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst2_locked", {28'b0, locked_a}, 32'd0);
        chk("rst2_rd0", rd_data_a, 32'h0);

        // dut_b: out-of-range write and read
        wr(2'd3, 2'b00, 32'hFFFF_FFFF, 1'b0);
        wr_en_b = 1'b1;
        step();
        wr_en_b = 1'b0;
        chk("oor_wrerr", {31'b0, wr_err_b}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 2'(i);
            #1;
            chk("oor_nochange", rd_data_b, 32'h0);
        end
        rd_addr = 2'd3;
        #1;
        chk("oor_rd", rd_data_b, 32'h0);
        chk("oor_rderr", {31'b0, rd_err_b}, 32'd0);

        // dut_b: flip shadow[2] bit 5, scrubber must catch it without a read
        rd_addr = 2'd0;
        chk("pre_fault_alert", {31'b0, alert_b}, 32'd0);
        force dut_b.g_reg[2].g_sh.shadow_q = 32'hFFFF_FFDF;
        cyc = 0;
        while ((alert_b !== 1'b1) && (cyc < 40)) begin
            step();
            cyc++;
        end
        chk("scrub_alert_in_time", {31'b0, (alert_b === 1'b1) && (cyc <= BOUND)}, 32'd1);
        rd_addr = 2'd2;
        #1;
        chk("fault_rderr", {31'b0, rd_err_b}, 32'd1);
        rd_addr = 2'd0;
        release dut_b.g_reg[2].g_sh.shadow_q;
        repeat (5) step();
        chk("alert_sticky", {31'b0, alert_b}, 32'd1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd_addr = 2'd2;
        #1;
        chk("rst3_alert", {31'b0, alert_b}, 32'd0);
        chk("rst3_rderr", {31'b0, rd_err_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
